// File: rtl/conv_quan_ctrl_gen_pkg.sv
// Shared definitions for the convolution quantisation control generator:
// FSM state encoding and default parameter values.
package conv_quan_ctrl_gen_pkg;

  localparam int unsigned DEF_COL_W    = 11;
  localparam int unsigned DEF_GRP_W    = 4;
  localparam int unsigned DEF_NPARA    = 16;
  localparam int unsigned DEF_PIPE_LAT = 32;
  localparam int unsigned DEF_WAIT_CYC = 5;

  // Wide enough for the largest supported start-up wait (31 cycles).
  localparam int unsigned WAIT_CNT_W   = 5;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    JUDGE_FIFO,
    JUDGE_READY,
    COMPUTE,
    ROW_END
  } state_t;

endpackage

// File: rtl/valid_delay_line.sv
// Resettable shift register delaying a single valid bit by DEPTH cycles.
module valid_delay_line
  import conv_quan_ctrl_gen_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_PIPE_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  if (DEPTH == 1) begin : g_one
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) sr <= '0;
      else      sr <= din;
    end
  end else begin : g_many
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) sr <= '0;
      else      sr <= {sr[DEPTH-2:0], din};
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/conv_quan_ctrl_gen.sv
// Frame/row sequencer issuing FIFO reads per (column, channel group), with
// quantisation-parameter group select and a latency-matched output valid.
module conv_quan_ctrl_gen
  import conv_quan_ctrl_gen_pkg::*;
#(
  parameter int unsigned COL_W    = DEF_COL_W,
  parameter int unsigned GRP_W    = DEF_GRP_W,
  parameter int unsigned NPARA    = DEF_NPARA,
  parameter int unsigned PIPE_LAT = DEF_PIPE_LAT,
  parameter int unsigned WAIT_CYC = DEF_WAIT_CYC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [COL_W-1:0]       col_num,
  input  logic [COL_W-1:0]       row_num,
  input  logic [GRP_W+2:0]       ch_out_num,
  input  logic                   fifo_valid,
  input  logic                   m_ready,
  output logic                   rd_en_fifo,
  output logic [NPARA-1:0]       para_select,
  output logic [COL_W+GRP_W-1:0] s_count_fifo,
  output logic                   m_valid,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned SC_W = COL_W + GRP_W;

  state_t                state, state_nxt;
  logic [COL_W-1:0]      col_q, row_q;
  logic [GRP_W-1:0]      grp_q;
  logic [COL_W-1:0]      col_cnt, row_cnt;
  logic [GRP_W-1:0]      grp_cnt;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [GRP_W-1:0]      grp_in;
  logic                  cfg_ok, accept, rd;
  logic                  last_grp, last_col, last_row;

  // Channels arrive as a count; the sequencer works in groups of eight.
  assign grp_in   = GRP_W'(ch_out_num >> 3);
  assign cfg_ok   = (col_num != '0) && (row_num != '0) && (grp_in != '0);
  assign accept   = (state == IDLE) && start;
  assign rd       = (state == COMPUTE) && m_ready;
  assign last_grp = (grp_cnt == grp_q - GRP_W'(1));
  assign last_col = (col_cnt == col_q - COL_W'(1));
  assign last_row = (row_cnt == row_q - COL_W'(1));

  assign rd_en_fifo = rd;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (start && cfg_ok) state_nxt = WAIT;
      WAIT:        if (wait_cnt == WAIT_CNT_W'(WAIT_CYC - 1)) state_nxt = JUDGE_FIFO;
      JUDGE_FIFO:  if (fifo_valid) state_nxt = JUDGE_READY;
      JUDGE_READY: if (m_ready) state_nxt = COMPUTE;
      COMPUTE:     if (rd && last_grp && last_col) state_nxt = ROW_END;
      ROW_END:     state_nxt = last_row ? IDLE : JUDGE_FIFO;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
      grp_q <= '0;
    end else if (accept) begin
      col_q <= col_num;
      row_q <= row_num;
      grp_q <= grp_in;
    end
  end

  // Product is refreshed every cycle from the latched config; the start-up
  // wait of at least two cycles covers the single register stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s_count_fifo <= '0;
    else      s_count_fifo <= SC_W'(col_q) * SC_W'(grp_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grp_cnt <= '0;
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (accept) begin
      grp_cnt <= '0;
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (rd) begin
      if (last_grp) begin
        grp_cnt <= '0;
        col_cnt <= last_col ? '0 : col_cnt + COL_W'(1);
      end else begin
        grp_cnt <= grp_cnt + GRP_W'(1);
      end
    end else if (state == ROW_END) begin
      row_cnt <= last_row ? '0 : row_cnt + COL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      para_select <= '0;
      done        <= 1'b0;
    end else begin
      para_select <= rd ? (NPARA'(1) << grp_cnt) : '0;
      done        <= (accept && !cfg_ok) || ((state == ROW_END) && last_row);
    end
  end

  valid_delay_line #(
    .DEPTH(PIPE_LAT)
  ) u_mv_dly (
    .clk (clk),
    .rst (rst),
    .din (rd),
    .dout(m_valid)
  );

endmodule

// File: tb/tb_conv_quan_ctrl_gen.sv
// Scoreboard bench for conv_quan_ctrl_gen: per-scenario tasks drive a frame
// and check read counts, timing, para_select and the delayed m_valid stream.
module tb_conv_quan_ctrl_gen;

  localparam int COL_W = 11;
  localparam int GRP_W = 4;
  localparam int NPARA = 16;
  localparam int LAT   = 12;
  localparam int WAITC = 5;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   start = 1'b0;
  logic [COL_W-1:0]       col_num = '0;
  logic [COL_W-1:0]       row_num = '0;
  logic [GRP_W+2:0]       ch_out_num = '0;
  logic                   fifo_valid = 1'b0;
  logic                   m_ready = 1'b0;
  logic                   rd_en_fifo;
  logic [NPARA-1:0]       para_select;
  logic [COL_W+GRP_W-1:0] s_count_fifo;
  logic                   m_valid, busy, done;

  int total = 0;
  int bad   = 0;

  int reads, done_cnt, done_cyc, busy_cnt, para_err, mv_err, bad_rd, rd_in_flow, mv_after_rst;
  int rd_cyc[$];
  int mv_q[$];
  logic [5:0]             rst_snap;
  logic [COL_W+GRP_W-1:0] scnt_mid, scnt_end;

  always #5 clk = ~clk;

  conv_quan_ctrl_gen #(
    .COL_W   (COL_W),
    .GRP_W   (GRP_W),
    .NPARA   (NPARA),
    .PIPE_LAT(LAT),
    .WAIT_CYC(WAITC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .col_num     (col_num),
    .row_num     (row_num),
    .ch_out_num  (ch_out_num),
    .fifo_valid  (fifo_valid),
    .m_ready     (m_ready),
    .rd_en_fifo  (rd_en_fifo),
    .para_select (para_select),
    .s_count_fifo(s_count_fifo),
    .m_valid     (m_valid),
    .busy        (busy),
    .done        (done)
  );

  // Drives one frame for a fixed number of cycles (cycle 0 = start pulse)
  // and gathers observations; expected m_valid cycles go into mv_q.
  task automatic run_frame(input int c, input int r, input int ch, input int ncyc,
                           input int ms, input int ml, input int fs, input int fl,
                           input int rc, input int sc, input int sc_col, input int mid);
    int grps, g;
    logic [NPARA-1:0] exp_para;
    grps = ch / 8; g = 0; exp_para = '0;
    reads = 0; done_cnt = 0; done_cyc = -1; busy_cnt = 0; para_err = 0; mv_err = 0;
    bad_rd = 0; rd_in_flow = 0; mv_after_rst = 0; rst_snap = '0; scnt_mid = '0;
    rd_cyc.delete(); mv_q.delete();
    @(posedge clk); #1;
    col_num = COL_W'(c); row_num = COL_W'(r); ch_out_num = (GRP_W+3)'(ch);
    start = 1'b1; m_ready = 1'b1; fifo_valid = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (!rst) begin mv_q.delete(); exp_para = '0; g = 0; end
      if (k == rc) rst_snap = {rd_en_fifo, busy, done, m_valid, |para_select, |s_count_fifo};
      if (rc >= 0 && k >= rc && m_valid) mv_after_rst++;
      if (para_select !== exp_para) para_err++;
      if (rd_en_fifo === 1'b1) begin
        reads++; rd_cyc.push_back(k); mv_q.push_back(k + LAT);
        if (!m_ready) bad_rd++;
        if (k >= fs && k < fs + fl) rd_in_flow++;
        exp_para = NPARA'(1) << g;
        g = (g + 1 >= grps) ? 0 : g + 1;
      end else begin
        exp_para = '0;
      end
      if (mv_q.size() > 0 && mv_q[0] == k) begin
        if (m_valid !== 1'b1) mv_err++;
        void'(mv_q.pop_front());
      end else if (m_valid !== 1'b0) begin
        mv_err++;
      end
      if (done) begin done_cnt++; done_cyc = k; end
      if (busy) busy_cnt++;
      if (k == mid) scnt_mid = s_count_fifo;
      @(posedge clk); #1;
      start = (k + 1 == sc) ? 1'b1 : 1'b0;
      if (k + 1 == sc) col_num = COL_W'(sc_col);
      m_ready    = (k + 1 >= ms && k + 1 < ms + ml) ? 1'b0 : 1'b1;
      fifo_valid = (k + 1 >= fs && k + 1 < fs + fl) ? 1'b0 : 1'b1;
      if (k + 1 == rc) rst = 1'b0;
      else if (k + 1 == rc + 3) rst = 1'b1;
    end
    mv_err += mv_q.size();
    scnt_end = s_count_fifo;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; fifo_valid = 1'b1; m_ready = 1'b1;
    col_num = 11'd4; row_num = 11'd2; ch_out_num = 7'd16;
    repeat (3) @(negedge clk);
    total++; if (rd_en_fifo !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b want=0", rd_en_fifo); end
    total++; if (para_select !== '0) begin bad++; $display("FAIL reset_para got=%h want=0", para_select); end
    total++; if (s_count_fifo !== '0) begin bad++; $display("FAIL reset_scount got=%0d want=0", s_count_fifo); end
    total++; if ({m_valid, busy, done} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {m_valid, busy, done}); end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic;
    run_frame(4, 2, 16, 50, 0, 0, 0, 0, -1, -1, 0, WAITC);
    total++; if (reads !== 16) begin bad++; $display("FAIL basic_reads got=%0d want=16", reads); end
    total++; if (rd_cyc[0] !== WAITC + 3) begin bad++; $display("FAIL basic_first_rd got=%0d want=%0d", rd_cyc[0], WAITC + 3); end
    total++; if (((rd_cyc.size() > 8) ? rd_cyc[8] : -1) !== WAITC + 14) begin bad++; $display("FAIL basic_row2_rd got=%0d want=%0d", (rd_cyc.size() > 8) ? rd_cyc[8] : -1, WAITC + 14); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL basic_done_cnt got=%0d want=1", done_cnt); end
    total++; if (done_cyc !== WAITC + 23) begin bad++; $display("FAIL basic_done_cyc got=%0d want=%0d", done_cyc, WAITC + 23); end
    total++; if (busy_cnt !== WAITC + 22) begin bad++; $display("FAIL basic_busy got=%0d want=%0d", busy_cnt, WAITC + 22); end
    total++; if (para_err !== 0) begin bad++; $display("FAIL basic_para errors=%0d want=0", para_err); end
    total++; if (mv_err !== 0) begin bad++; $display("FAIL basic_mvalid errors=%0d want=0", mv_err); end
    total++; if (scnt_mid !== 15'd8) begin bad++; $display("FAIL basic_scount_in_wait got=%0d want=8", scnt_mid); end
    total++; if (scnt_end !== 15'd8) begin bad++; $display("FAIL basic_scount got=%0d want=8", scnt_end); end
  endtask

  task automatic test_stall;
    run_frame(3, 1, 8, 40, WAITC + 4, 5, 0, 0, -1, -1, 0, 0);
    total++; if (reads !== 3) begin bad++; $display("FAIL stall_reads got=%0d want=3", reads); end
    total++; if (bad_rd !== 0) begin bad++; $display("FAIL stall_rd_without_ready got=%0d want=0", bad_rd); end
    total++; if (((rd_cyc.size() > 1) ? rd_cyc[1] : -1) !== WAITC + 9) begin bad++; $display("FAIL stall_resume got=%0d want=%0d", (rd_cyc.size() > 1) ? rd_cyc[1] : -1, WAITC + 9); end
    total++; if (done_cyc !== WAITC + 12) begin bad++; $display("FAIL stall_done_cyc got=%0d want=%0d", done_cyc, WAITC + 12); end
    total++; if (mv_err !== 0) begin bad++; $display("FAIL stall_mvalid errors=%0d want=0", mv_err); end
    total++; if (para_err !== 0) begin bad++; $display("FAIL stall_para errors=%0d want=0", para_err); end
  endtask

  task automatic test_zero_ch;
    run_frame(4, 2, 0, 10, 0, 0, 0, 0, -1, -1, 0, 0);
    total++; if (reads !== 0) begin bad++; $display("FAIL zero_reads got=%0d want=0", reads); end
    total++; if (busy_cnt !== 0) begin bad++; $display("FAIL zero_busy got=%0d want=0", busy_cnt); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL zero_done_cnt got=%0d want=1", done_cnt); end
    total++; if (done_cyc !== 1) begin bad++; $display("FAIL zero_done_cyc got=%0d want=1", done_cyc); end
  endtask

  task automatic test_fifo_gap;
    run_frame(2, 2, 16, 60, 0, 0, WAITC + 7, 20, -1, -1, 0, 0);
    total++; if (reads !== 8) begin bad++; $display("FAIL gap_reads got=%0d want=8", reads); end
    total++; if (rd_in_flow !== 0) begin bad++; $display("FAIL gap_reads_while_empty got=%0d want=0", rd_in_flow); end
    total++; if (((rd_cyc.size() > 4) ? rd_cyc[4] : -1) !== WAITC + 29) begin bad++; $display("FAIL gap_row2_rd got=%0d want=%0d", (rd_cyc.size() > 4) ? rd_cyc[4] : -1, WAITC + 29); end
    total++; if (done_cyc !== WAITC + 34) begin bad++; $display("FAIL gap_done_cyc got=%0d want=%0d", done_cyc, WAITC + 34); end
    total++; if (mv_err !== 0) begin bad++; $display("FAIL gap_mvalid errors=%0d want=0", mv_err); end
  endtask

  task automatic test_reset_mid;
    run_frame(4, 2, 16, 60, 0, 0, 0, 0, WAITC + 16, -1, 0, 0);
    total++; if (rst_snap !== 6'b0) begin bad++; $display("FAIL rstmid_outputs got=%b want=000000", rst_snap); end
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL rstmid_done got=%0d want=0", done_cnt); end
    total++; if (mv_after_rst !== 0) begin bad++; $display("FAIL rstmid_mvalid_after got=%0d want=0", mv_after_rst); end
    total++; if (reads !== 10) begin bad++; $display("FAIL rstmid_reads got=%0d want=10", reads); end
    total++; if (mv_err !== 0) begin bad++; $display("FAIL rstmid_mvalid errors=%0d want=0", mv_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_restart_ignored;
    run_frame(3, 1, 16, 40, 0, 0, 0, 0, -1, WAITC + 5, 7, WAITC + 7);
    total++; if (reads !== 6) begin bad++; $display("FAIL restart_reads got=%0d want=6", reads); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL restart_done_cnt got=%0d want=1", done_cnt); end
    total++; if (done_cyc !== WAITC + 10) begin bad++; $display("FAIL restart_done_cyc got=%0d want=%0d", done_cyc, WAITC + 10); end
    total++; if (scnt_mid !== 15'd6) begin bad++; $display("FAIL restart_scount_mid got=%0d want=6", scnt_mid); end
    total++; if (scnt_end !== 15'd6) begin bad++; $display("FAIL restart_scount_end got=%0d want=6", scnt_end); end
    total++; if (para_err !== 0) begin bad++; $display("FAIL restart_para errors=%0d want=0", para_err); end
    total++; if (mv_err !== 0) begin bad++; $display("FAIL restart_mvalid errors=%0d want=0", mv_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_ch();
    test_fifo_gap();
    test_reset_mid();
    test_restart_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
